vga_frame_checker: RTL and testbench

- Passive sink at the far end of the vga_if pixel stream, after the last draw stage and in parallel with the VGA output pins.
- Rebuilds the expected 800x600@60 timing on its own and checks hcount, vcount, sync and blank on every clock.
- Computes a CRC-16 over the active-area rgb of each frame and reports a per-frame signature, a frame counter and sticky error flags.
- Used for on-board debug and as the scoreboard end of draw-stage testbenches.

---
 rtl/vga_frame_checker_pkg.sv | 27 ++
 rtl/vga_if.sv | 12 +
 rtl/vga_frame_checker_crc16_rgb_step.sv | 17 +
 rtl/vga_frame_checker.sv | 137 +++++++++++++
 tb/tb_vga_frame_checker.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_checker_pkg.sv
// vga_pkg: 800x600@60 timing constants, CRC settings, error-bit indices and checker types
package vga_pkg;
  localparam int HOR_PIXELS  = 800;
  localparam int VER_PIXELS  = 600;
  localparam int HOR_TOTAL   = 1056;
  localparam int VER_TOTAL   = 628;
  localparam int HSYNC_START = 840;
  localparam int HSYNC_STOP  = 968;
  localparam int VSYNC_START = 601;
  localparam int VSYNC_STOP  = 605;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int ERR_CNT  = 0;
  localparam int ERR_HS   = 1;
  localparam int ERR_VS   = 2;
  localparam int ERR_BLNK = 3;
  typedef enum logic {SEARCH, LOCKED} chk_state_t;
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vga_sample_t;
endpackage

// File: rtl/vga_if.sv
// vga_if: pixel stream bundle (counters, syncs, blanks, rgb); modport in for sinks, out for sources
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_frame_checker_crc16_rgb_step.sv
// crc16_rgb_step: combinational CRC-16-CCITT update over one 12-bit pixel, data[11] first
//   crc_in  : running CRC
//   data    : rgb pixel
//   crc_out : CRC after all 12 bits
module crc16_rgb_step (
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);
  import vga_pkg::*;
  logic [15:0] c;
  always_comb begin
    c = crc_in;
    for (int i = 11; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
  assign crc_out = c;
endmodule

// File: rtl/vga_frame_checker.sv
// vga_frame_checker: passive checker of a vga_if stream timing plus per-frame CRC-16 of active rgb
//   clk, rst (sync, active-high) ; vga_in : stream under test ; err_clear : clears sticky flags
//   locked : synchronised ; err_flags : [0] count [1] hsync [2] vsync [3] blank
//   frame_crc/crc_valid : signature of last good frame ; frame_count : good frames
//   err_count : mismatch counter, built only when VGA_CHECKER_STATS_EN is defined, else 0
module vga_frame_checker #(
  parameter int HOR_PIXELS  = vga_pkg::HOR_PIXELS,
  parameter int VER_PIXELS  = vga_pkg::VER_PIXELS,
  parameter int HOR_TOTAL   = vga_pkg::HOR_TOTAL,
  parameter int VER_TOTAL   = vga_pkg::VER_TOTAL,
  parameter int HSYNC_START = vga_pkg::HSYNC_START,
  parameter int HSYNC_STOP  = vga_pkg::HSYNC_STOP,
  parameter int VSYNC_START = vga_pkg::VSYNC_START,
  parameter int VSYNC_STOP  = vga_pkg::VSYNC_STOP
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vga_in,
  input  logic        err_clear,
  output logic        locked,
  output logic [3:0]  err_flags,
  output logic [15:0] frame_crc,
  output logic        crc_valid,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);
  import vga_pkg::*;
  localparam logic [10:0] HP  = 11'(HOR_PIXELS);
  localparam logic [10:0] VP  = 11'(VER_PIXELS);
  localparam logic [10:0] HT1 = 11'(HOR_TOTAL - 1);
  localparam logic [10:0] VT1 = 11'(VER_TOTAL - 1);
  localparam logic [10:0] HSS = 11'(HSYNC_START);
  localparam logic [10:0] HSE = 11'(HSYNC_STOP);
  localparam logic [10:0] VSS = 11'(VSYNC_START);
  localparam logic [10:0] VSE = 11'(VSYNC_STOP);
  vga_sample_t s1_q;
  logic        s1_vld_q;
  chk_state_t  state_q, state_d;
  logic [10:0] eh_q, eh_d, ev_q, ev_d, ceh, cev;
  logic [15:0] crc_q, crc_d, crc_nx, fcrc_q, fcrc_d, fc_q, fc_d;
  logic        ok_q, ok_d, cv_q, cv_d;
  logic        chk, bad, active, exp_hb, exp_vb, exp_hs, exp_vs;
  logic [3:0]  mis, flags_q, flags_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      state_q  <= SEARCH;
      eh_q     <= '0;
      ev_q     <= '0;
      crc_q    <= CRC_INIT;
      ok_q     <= 1'b0;
      fcrc_q   <= '0;
      cv_q     <= 1'b0;
      fc_q     <= '0;
      flags_q  <= '0;
    end else begin
      s1_q     <= {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk, vga_in.rgb};
      s1_vld_q <= 1'b1;
      state_q  <= state_d;
      eh_q     <= eh_d;
      ev_q     <= ev_d;
      crc_q    <= crc_d;
      ok_q     <= ok_d;
      fcrc_q   <= fcrc_d;
      cv_q     <= cv_d;
      fc_q     <= fc_d;
      flags_q  <= flags_d;
    end
  end
  // While searching, the only sample worth checking is the frame origin
  assign ceh    = state_q == LOCKED ? eh_q : '0;
  assign cev    = state_q == LOCKED ? ev_q : '0;
  assign exp_hb = ceh >= HP;
  assign exp_vb = cev >= VP;
  assign exp_hs = ceh >= HSS && ceh < HSE;
  assign exp_vs = cev >= VSS && cev < VSE;
  assign active = !exp_hb && !exp_vb;
  assign chk    = s1_vld_q && (state_q == LOCKED || (s1_q.h == '0 && s1_q.v == '0));
  always_comb begin
    mis           = '0;
    mis[ERR_CNT]  = chk && (s1_q.h != ceh || s1_q.v != cev);
    mis[ERR_HS]   = chk && s1_q.hs != exp_hs;
    mis[ERR_VS]   = chk && s1_q.vs != exp_vs;
    mis[ERR_BLNK] = chk && (s1_q.hb != exp_hb || s1_q.vb != exp_vb);
  end
  assign bad = |mis;
  // A fresh lock starts its frame from CRC_INIT, so the origin pixel is always included
  crc16_rgb_step u_crc (
    .crc_in  (state_q == LOCKED ? crc_q : CRC_INIT),
    .data    (s1_q.rgb),
    .crc_out (crc_nx)
  );
  always_comb begin
    state_d = state_q;
    eh_d    = eh_q;
    ev_d    = ev_q;
    crc_d   = crc_q;
    ok_d    = ok_q;
    fcrc_d  = fcrc_q;
    cv_d    = 1'b0;
    fc_d    = fc_q;
    flags_d = (err_clear ? 4'b0000 : flags_q) | mis;
    if (chk && bad) begin
      state_d = SEARCH;
      ok_d    = 1'b0;
    end else if (chk) begin
      state_d = LOCKED;
      eh_d    = ceh == HT1 ? '0 : ceh + 11'd1;
      ev_d    = ceh != HT1 ? cev : cev == VT1 ? '0 : cev + 11'd1;
      ok_d    = (ceh == '0 && cev == '0) ? 1'b1 : ok_q;
      crc_d   = active ? crc_nx : crc_q;
      if (ceh == HP - 11'd1 && cev == VP - 11'd1) begin
        crc_d  = CRC_INIT;
        fcrc_d = ok_q ? crc_nx : fcrc_q;
        cv_d   = ok_q;
        fc_d   = ok_q ? fc_q + 16'd1 : fc_q;
      end
    end
  end
  assign locked      = state_q == LOCKED;
  assign err_flags   = flags_q;
  assign frame_crc   = fcrc_q;
  assign crc_valid   = cv_q;
  assign frame_count = fc_q;
`ifdef VGA_CHECKER_STATS_EN
  logic [15:0] ec_q, ec_d;
  always_comb begin
    ec_d = err_clear ? 16'h0000 : ec_q;
    ec_d = (bad && ec_d != 16'hFFFF) ? ec_d + 16'd1 : ec_d;
  end
  always_ff @(posedge clk) ec_q <= rst ? 16'h0000 : ec_d;
  assign err_count = ec_q;
`else
  assign err_count = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: randomized stream with injected faults against a position-based reference model
module tb_vga_frame_checker;
  localparam int HP = 16, VP = 8, HT = 24, VT = 12;
  localparam int HSS = 18, HSE = 21, VSS = 9, VSE = 10;
  localparam int FT = HT * VT;
  localparam int LAST = (VP - 1) * HT + HP - 1;
`ifdef VGA_CHECKER_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, err_clear = 1'b0;
  logic locked, crc_valid;
  logic [3:0] err_flags;
  logic [15:0] frame_crc, frame_count, err_count;
  logic [10:0] s_h = '0, s_v = '0;
  logic s_hs = 1'b0, s_vs = 1'b0, s_hb = 1'b0, s_vb = 1'b0;
  logic [11:0] s_rgb = '0;
  logic fixed = 1'b0;
  int sp = 0;
  int n_vec = 0, n_bad = 0;
  vga_if vif ();
  assign vif.hcount = s_h;
  assign vif.vcount = s_v;
  assign vif.hsync  = s_hs;
  assign vif.vsync  = s_vs;
  assign vif.hblnk  = s_hb;
  assign vif.vblnk  = s_vb;
  assign vif.rgb    = s_rgb;
  vga_frame_checker #(
    .HOR_PIXELS(HP), .VER_PIXELS(VP), .HOR_TOTAL(HT), .VER_TOTAL(VT),
    .HSYNC_START(HSS), .HSYNC_STOP(HSE), .VSYNC_START(VSS), .VSYNC_STOP(VSE)
  ) dut (
    .clk(clk), .rst(rst), .vga_in(vif), .err_clear(err_clear),
    .locked(locked), .err_flags(err_flags), .frame_crc(frame_crc),
    .crc_valid(crc_valid), .frame_count(frame_count), .err_count(err_count)
  );
  always #5 clk = ~clk;
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [11:0] d);
    for (int i = 11; i >= 0; i--) c = crc_bit(c, d[i]);
    return c;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // fault: 0 none, 1 hsync forced low, 2 skip one position, 3 vblnk inverted, 4 random bit flip
  task automatic step(input int fault, input logic clr, input logic r);
    int h, v, b;
    logic [37:0] w;
    @(posedge clk);
    #1;
    if (fault == 2) sp = (sp + 1) % FT;
    h = sp % HT;
    v = sp / HT;
    s_h   = 11'(h);
    s_v   = 11'(v);
    s_hb  = h >= HP;
    s_vb  = v >= VP;
    s_hs  = h >= HSS && h < HSE;
    s_vs  = v >= VSS && v < VSE;
    s_rgb = fixed ? 12'h888 : 12'($urandom);
    if (fault == 1) s_hs = 1'b0;
    if (fault == 3) s_vb = ~s_vb;
    if (fault == 4) begin
      b = $urandom_range(0, 37);
      w = {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_rgb};
      w[b] = ~w[b];
      {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_rgb} = w;
    end
    err_clear = clr;
    rst = r;
    sp = (sp + 1) % FT;
  endtask
  task automatic run(input int n);
    repeat (n) step(0, 1'b0, 1'b0);
  endtask
  task automatic run_to(input int p);
    while (sp != p) step(0, 1'b0, 1'b0);
  endtask
  // Reference model: tracks the expected raster position as one linear index into the frame
  logic m_init = 1'b0, m_vld = 1'b0, m_lock = 1'b0, m_ok = 1'b0, m_cv = 1'b0;
  int m_pos = 0, eh, ev;
  logic [15:0] m_crc = 16'hFFFF, m_fcrc = '0, m_fc = '0, m_ec = '0;
  logic [3:0] m_fl = '0, mis;
  logic [10:0] q_h = '0, q_v = '0;
  logic q_hs = 1'b0, q_vs = 1'b0, q_hb = 1'b0, q_vb = 1'b0;
  logic [11:0] q_rgb = '0;
  always @(negedge clk) begin
    if (m_init) begin
      check("locked", 32'(locked), 32'(m_lock));
      check("err_flags", 32'(err_flags), 32'(m_fl));
      check("frame_crc", 32'(frame_crc), 32'(m_fcrc));
      check("crc_valid", 32'(crc_valid), 32'(m_cv));
      check("frame_count", 32'(frame_count), 32'(m_fc));
      check("err_count", 32'(err_count), 32'(m_ec));
    end
    if (rst) begin
      m_init = 1'b1; m_vld = 1'b0; m_lock = 1'b0; m_ok = 1'b0; m_cv = 1'b0; m_pos = 0;
      m_crc = 16'hFFFF; m_fcrc = '0; m_fc = '0; m_ec = '0; m_fl = '0;
    end else begin
      m_cv = 1'b0;
      if (err_clear) begin
        m_fl = '0;
        m_ec = '0;
      end
      if (m_vld && (m_lock || (q_h == 0 && q_v == 0))) begin
        eh = m_lock ? m_pos % HT : 0;
        ev = m_lock ? m_pos / HT : 0;
        mis[0] = q_h != eh || q_v != ev;
        mis[1] = q_hs != (eh >= HSS && eh < HSE);
        mis[2] = q_vs != (ev >= VSS && ev < VSE);
        mis[3] = q_hb != (eh >= HP) || q_vb != (ev >= VP);
        m_fl |= mis;
        if (mis != 0) begin
          m_lock = 1'b0;
          m_ok = 1'b0;
          if (STATS && m_ec != 16'hFFFF) m_ec++;
        end else begin
          if (!m_lock) begin
            m_lock = 1'b1;
            m_pos = 0;
            m_crc = 16'hFFFF;
          end
          if (m_pos == 0) m_ok = 1'b1;
          if (eh < HP && ev < VP) m_crc = crc_px(m_crc, q_rgb);
          if (m_pos == LAST) begin
            if (m_ok) begin
              m_fcrc = m_crc;
              m_cv = 1'b1;
              m_fc++;
            end
            m_crc = 16'hFFFF;
          end
          m_pos = (m_pos + 1) % FT;
        end
      end
      m_vld = 1'b1;
    end
    {q_h, q_v, q_hs, q_vs, q_hb, q_vb, q_rgb} = {s_h, s_v, s_hs, s_vs, s_hb, s_vb, s_rgb};
  end
  initial begin
    logic [15:0] c;
    string s;
    byte ch;
    s = "123456789";
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      ch = s[i];
      for (int b = 7; b >= 0; b--) c = crc_bit(c, ch[b]);
    end
    check("crc_model_check_value", 32'(c), 32'h29B1);
    // constant rgb, three clean frames
    fixed = 1'b1;
    repeat (3) step(0, 1'b0, 1'b1);
    sp = 0;
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check("t1_locked_after_1clk", 32'(locked), 32'd0);
    step(0, 1'b0, 1'b0);
    check("t1_locked_after_2clk", 32'(locked), 32'd1);
    run(3 * FT);
    check("t1_frame_count", 32'(frame_count), 32'd3);
    check("t1_err_flags", 32'(err_flags), 32'd0);
    fixed = 1'b0;
    // start mid-frame
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    sp = (VP / 2) * HT + HP / 2;
    run_to(0);
    check("t2_no_count_partial", 32'(frame_count), 32'd0);
    run(FT + 2);
    check("t2_frame_count", 32'(frame_count), 32'd1);
    // hsync forced low inside the second frame
    run_to(0);
    run_to(HT + HSS + 2);
    step(1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check("t3_err_flags", 32'(err_flags), 32'b0010);
    check("t3_locked", 32'(locked), 32'd0);
    run_to(0);
    run(FT + 2);
    check("t3_frame_count", 32'(frame_count), 32'd3);
    // skipped hcount
    step(0, 1'b1, 1'b0);
    run_to(2 * HT + 10);
    step(2, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check("t4_err_flags", 32'(err_flags), 32'b0001);
    check("t4_locked", 32'(locked), 32'd0);
    check("t4_err_count", 32'(err_count), 32'(STATS));
    // err_clear together with a new vblnk mismatch, then alone
    run_to(0);
    run(3 * HT);
    step(3, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    check("t5_set_wins", 32'(err_flags), 32'b1000);
    check("t5_err_count", 32'(err_count), 32'(STATS));
    step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    check("t5_cleared", 32'(err_flags), 32'd0);
    check("t5_err_count_cleared", 32'(err_count), 32'd0);
    // reset while the last active pixel is in S1
    run_to(0);
    run_to(LAST);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_crc_valid", 32'(crc_valid), 32'd0);
    check("t6_frame_crc", 32'(frame_crc), 32'd0);
    check("t6_frame_count", 32'(frame_count), 32'd0);
    check("t6_err_flags", 32'(err_flags), 32'd0);
    run_to(0);
    run(FT + 2);
    check("t6_relock_count", 32'(frame_count), 32'd1);
    // random faults, clears and resets
    for (int i = 0; i < 12 * FT; i++)
      step($urandom_range(0, 199) == 0 ? int'($urandom_range(1, 4)) : 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 1999) == 0);
    run(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
